// File: rtl/universal_shift_register.sv
// Multi-mode shift register: parallel load, LSR/LSL/ASR/ROR single steps,
// and an auto-sequenced burst of N shifts with a busy/done handshake.
module universal_shift_register #(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic             shift,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_LSL = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [1:0]       burst_mode_q, burst_mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Returns {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] do_shift(input logic [1:0] m,
                                                input logic [WIDTH-1:0] v,
                                                input logic si);
        case (m)
            M_LSR:   do_shift = {v[0], si, v[WIDTH-1:1]};
            M_LSL:   do_shift = {v[WIDTH-1], v[WIDTH-2:0], si};
            M_ASR:   do_shift = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: do_shift = {v[0], v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        burst_mode_d = burst_mode_q;
        remaining_d  = remaining_q;
        q_d          = q_q;
        so_d         = so_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        if (!load_n) begin
            // A load always wins and silently aborts any burst in flight.
            q_d         = load_val;
            state_d     = IDLE;
            busy_d      = 1'b0;
            remaining_d = '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                burst_mode_d = mode;
                remaining_d  = count;
                if (count != '0) begin
                    state_d = BURST;
                    busy_d  = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end else if (shift) begin
                {so_d, q_d} = do_shift(mode, q_q, serial_in);
            end
        end else begin
            {so_d, q_d} = do_shift(burst_mode_q, q_q, serial_in);
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            burst_mode_q <= 2'b00;
            remaining_q  <= '0;
            q_q          <= RESET_VAL;
            so_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_mode_q <= burst_mode_d;
            remaining_q  <= remaining_d;
            q_q          <= q_d;
            so_q         <= so_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign q          = q_q;
    assign serial_out = so_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register: expectations are queued as
// stimulus is driven and popped one clock later (or immediately for async reset).
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_n = 1'b1;
    logic [7:0] load_val = '0;
    logic [1:0] mode = 2'b00;
    logic       serial_in = 1'b0;
    logic       shift = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = '0;
    logic [7:0] q;
    logic       serial_out, busy, done;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    universal_shift_register #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .load_n(load_n), .load_val(load_val),
        .mode(mode), .serial_in(serial_in), .shift(shift), .start(start),
        .count(count), .q(q), .serial_out(serial_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic push(input string tag, input logic [7:0] eq, input logic eso,
                        input logic ebusy, input logic edone);
        exp_t e;
        e.tag = tag; e.q = eq; e.so = eso; e.busy = ebusy; e.done = edone;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".q"},    32'(q),          32'(e.q));
            chk({e.tag, ".so"},   32'(serial_out), 32'(e.so));
            chk({e.tag, ".busy"}, 32'(busy),       32'(e.busy));
            chk({e.tag, ".done"}, 32'(done),       32'(e.done));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_load(input logic [7:0] v, input logic so_now);
        load_n = 1'b0; load_val = v;
        push("load", v, so_now, 1'b0, 1'b0);
        tick();
        load_n = 1'b1;
    endtask

    initial begin
        logic [7:0] e;
        logic       eso;

        #3;
        push("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        drain();
        #10 reset_n = 1'b1;

        // 1: single LSR with serial_in=1
        do_load(8'hA5, 1'b0);
        mode = 2'b00; serial_in = 1'b1; shift = 1'b1;
        push("lsr1", 8'hD2, 1'b1, 1'b0, 1'b0);
        tick();
        shift = 1'b0;

        // 2: ASR burst of 3
        do_load(8'h90, 1'b1);
        mode = 2'b10; count = 4'd3; start = 1'b1;
        push("asr_start", 8'h90, 1'b1, 1'b1, 1'b0);
        tick();
        start = 1'b0; mode = 2'b00;
        push("asr_s1", 8'hC8, 1'b0, 1'b1, 1'b0); tick();
        push("asr_s2", 8'hE4, 1'b0, 1'b1, 1'b0); tick();
        push("asr_s3", 8'hF2, 1'b0, 1'b0, 1'b1); tick();
        push("asr_after", 8'hF2, 1'b0, 1'b0, 1'b0); tick();

        // 3: ROR burst of 8 with mode toggling mid-burst
        do_load(8'h3C, 1'b0);
        mode = 2'b11; count = 4'd8; start = 1'b1;
        push("ror_start", 8'h3C, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        e = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            mode = mode + 2'd1;
            eso = e[0];
            e = {e[0], e[7:1]};
            push($sformatf("ror_s%0d", i), e, eso, (i != 7), (i == 7));
            tick();
        end
        chk("ror_roundtrip", 32'(q), 32'h3C);

        // 4: LSL burst aborted by load on 2nd burst cycle
        do_load(8'h01, 1'b0);
        mode = 2'b01; count = 4'd5; serial_in = 1'b0; start = 1'b1;
        push("lsl_start", 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        push("lsl_s1", 8'h02, 1'b0, 1'b1, 1'b0);
        tick();
        load_n = 1'b0; load_val = 8'h77;
        push("abort", 8'h77, 1'b0, 1'b0, 1'b0);
        tick();
        load_n = 1'b1;
        push("abort_nodone1", 8'h77, 1'b0, 1'b0, 1'b0); tick();
        push("abort_nodone2", 8'h77, 1'b0, 1'b0, 1'b0); tick();

        // 5: count=0, then start/shift held during a burst
        count = 4'd0; start = 1'b1;
        push("cnt0_done", 8'h77, 1'b0, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        push("cnt0_once", 8'h77, 1'b0, 1'b0, 1'b0);
        tick();
        mode = 2'b10; count = 4'd2; start = 1'b1;
        push("asr2_start", 8'h77, 1'b0, 1'b1, 1'b0);
        tick();
        shift = 1'b1; count = 4'd9; mode = 2'b01;
        push("ign_s1", 8'h3B, 1'b1, 1'b1, 1'b0);
        tick();
        push("ign_s2", 8'h1D, 1'b1, 1'b0, 1'b1);
        tick();
        start = 1'b0; shift = 1'b0;
        push("ign_after", 8'h1D, 1'b1, 1'b0, 1'b0);
        tick();

        // 6: async reset between edges mid-burst
        mode = 2'b11; count = 4'd4; start = 1'b1;
        push("rst_start", 8'h1D, 1'b1, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        push("rst_s1", 8'h8E, 1'b1, 1'b1, 1'b0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        push("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        drain();
        push("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        push("rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        mode = 2'b01; serial_in = 1'b1; shift = 1'b1;
        push("rst_lsl", 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        shift = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
